tt_capture_checker: RTL
=======================

Name: tt_capture_checker

Overview:
- Sequential, self-checking response end for a 4-input combinational function under test.
- Drives every input vector 0..15 to the function, waits a fixed settle time, then samples the 1-bit response and records it into a 16-bit captured truth table.
- Compares each sample against a golden truth-table mask and reports an error count, the first failing index and pass/fail.
- Serves as the hardware replacement for manual waveform inspection of a dataflow model such as (AB' + A'B)(C + D').

Parameters:
- EXPECTED, 16'h0DD0, golden truth table. Bit i is the required F for input vector i = {A,B,C,D}. The default encodes (A^B)&(C|~D).
- SETTLE, 2, cycles each vector is held before sampling. Legal range 1..15; values below 1 behave as 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- vec_out  out  4  vector to the function under test, {A,B,C,D}; A is bit 3.
- f_in  in  1  response of the function under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  done && err_count==0.
- captured  out  16  bit i holds the f_in sampled for vector i.
- err_count  out  5  number of mismatching vectors, 0..16.
- first_err_idx  out  4  index of the lowest mismatching vector.
- first_err_valid  out  1  high once any mismatch has been recorded.

Behaviour:
- Reset (async assert, sync release): state IDLE. busy, done, pass and first_err_valid are 0. vec_out, captured, err_count and first_err_idx are 0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE, start=1 at an edge:
  - next state APPLY; busy=1, vec_out=0.
  - captured, err_count, first_err_idx and first_err_valid cleared; settle counter = 0.
- APPLY:
  - vec_out held; settle counter increments each edge.
  - When counter == SETTLE-1, next state SAMPLE. APPLY therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle), at the closing edge:
  - captured[vec_out] <= f_in.
  - On f_in != EXPECTED[vec_out]: err_count increments. If first_err_valid=0, first_err_idx <= vec_out and first_err_valid <= 1.
  - If vec_out == 15: next state DONE, busy=0, done=1. vec_out stays 15; it does not wrap to 0.
  - Otherwise: vec_out increments, settle counter resets, next state APPLY.
- Per-vector cost is SETTLE+1 cycles. done rises 16*(SETTLE+1) edges after the start edge, which is 48 for the default.
- DONE: all results are held stable. start=1 behaves exactly like start in IDLE, clearing results, dropping done and restarting at vector 0.
- start while busy is ignored; the sweep is not disturbed.
- f_in is sampled only at the SAMPLE closing edge; f_in toggles during APPLY have no effect.
- rst_n low mid-sweep: immediate return to reset values. No partial results are retained and no done pulse occurs.
- err_count saturates naturally at 16; no overflow is possible.

Test Plan:
- Golden model of (A^B)&(C|~D) on f_in, SETTLE=2, start pulse:
  - vec_out steps 0..15, each held 3 cycles.
  - done at +48 cycles; captured=16'h0DD0, err_count=0, pass=1, first_err_valid=0.
- f_in tied 0: captured=16'h0000, err_count=6, first_err_idx=4, first_err_valid=1, pass=0.
- f_in = inverted golden model: captured=16'hF22F, err_count=16, first_err_idx=0.
- start re-pulsed at vector 5 during a sweep: ignored; done still exactly 48 cycles after the original start, and results unchanged versus the single-start run.
- rst_n pulsed low while vec_out=7, asynchronous to clk:
  - all outputs return to 0 without waiting for a clock edge.
  - a subsequent start completes a full clean sweep.
- After a failing sweep, with DONE held: swap in the golden model and pulse start.
  - done drops the next cycle and err_count clears.
  - The final result is pass=1 and captured=16'h0DD0.

Source files
------------

// File: rtl/tt_capture_checker.sv
// Sweeps all 16 input vectors of a 4-input function, captures its truth
// table and scores it against a golden mask.
module tt_capture_checker #(
  parameter logic [15:0] EXPECTED = 16'h0DD0,
  parameter int          SETTLE   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  vec_out,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        first_err_valid
);

  localparam int SET_EFF =
    (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
  localparam logic [3:0] LAST = 4'(SET_EFF - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       mism;

  assign mism = (f_in != EXPECTED[vec_out]);
  assign busy = (state == APPLY) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_count == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      vec_out         <= 4'd0;
      captured        <= 16'd0;
      err_count       <= 5'd0;
      first_err_idx   <= 4'd0;
      first_err_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= APPLY;
            cnt             <= 4'd0;
            vec_out         <= 4'd0;
            captured        <= 16'd0;
            err_count       <= 5'd0;
            first_err_idx   <= 4'd0;
            first_err_valid <= 1'b0;
          end
        end
        APPLY: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          captured[vec_out] <= f_in;
          if (mism) begin
            err_count <= err_count + 5'd1;
            if (!first_err_valid) begin
              first_err_idx   <= vec_out;
              first_err_valid <= 1'b1;
            end
          end
          // Last vector parks at 15 so the final stimulus stays visible.
          if (vec_out == 4'hF) begin
            state <= DONE;
          end else begin
            vec_out <= vec_out + 4'd1;
            cnt     <= 4'd0;
            state   <= APPLY;
          end
        end
      endcase
    end
  end

endmodule
